// File: rtl/ingress_buffer_if.sv
// Host bus and per-channel stream signals for ingress_buffer.
// The host or bench drives through master; the buffer itself uses slave.
interface ingress_buffer_if #(
    parameter int DATA_W = 32
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [3:0]        address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic [DATA_W-1:0] input3;
    logic              in_valid1;
    logic              in_valid2;
    logic              in_valid3;
    logic              in_ready1;
    logic              in_ready2;
    logic              in_ready3;

    modport master (
        output chipselect, write, read, address, writedata,
        output in_ready1, in_ready2, in_ready3,
        input  readdata, input1, input2, input3,
        input  in_valid1, in_valid2, in_valid3
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        input  in_ready1, in_ready2, in_ready3,
        output readdata, input1, input2, input3,
        output in_valid1, in_valid2, in_valid3
    );
endinterface

// File: rtl/ingress_buffer.sv
// Host-to-fabric ingress buffer: three bus-written FIFOs, each streamed out
// through a RAM -> prefetch -> show-ahead output register pipeline.
module ingress_fifo #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   level_o
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d, ram_cnt_s;
    logic              pf_valid_q, pf_valid_d;
    logic [DATA_W-1:0] pf_data_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              push_ok_s, pop_s, out_load_s, pf_move_s, rd_en_s;

    // Next-state: words still in RAM are level minus those held in the two stages.
    always_comb begin
        push_ok_s  = push_i && (level_q != DEPTH);
        pop_s      = out_valid_q && ready_i;
        out_load_s = !out_valid_q || pop_s;
        pf_move_s  = pf_valid_q && out_load_s;
        ram_cnt_s  = level_q - (ADDR_W+1)'(pf_valid_q) - (ADDR_W+1)'(out_valid_q);
        rd_en_s    = (ram_cnt_s != '0) && (!pf_valid_q || pf_move_s);

        wr_ptr_d    = push_ok_s ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d    = rd_en_s ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        out_valid_d = out_load_s ? pf_valid_q : 1'b1;
        out_data_d  = pf_move_s ? pf_data_q : out_data_q;
        if (rd_en_s) begin
            pf_valid_d = 1'b1;
        end else if (pf_move_s) begin
            pf_valid_d = 1'b0;
        end else begin
            pf_valid_d = pf_valid_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state and the show-ahead output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pf_valid_q  <= pf_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Synchronous-read RAM; its read register is the prefetch stage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
        if (rd_en_s) begin
            pf_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_o  = out_data_q;
    assign valid_o = out_valid_q;
    assign level_o = level_q;
endmodule

module ingress_buffer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    ingress_buffer_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        push_s, ready_s, valid_s, full_s, empty_s, clr_s;
    logic [DATA_W-1:0] data_s [3];
    logic [ADDR_W:0]   level_s [3];
    logic [2:0]        ovf_q, ovf_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              wr_s, rd_s;

    assign ready_s = {bus.in_ready3, bus.in_ready2, bus.in_ready1};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        ingress_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push_s[g]),
            .wdata_i (bus.writedata),
            .ready_i (ready_s[g]),
            .data_o  (data_s[g]),
            .valid_o (valid_s[g]),
            .level_o (level_s[g])
        );
        assign full_s[g]  = (level_s[g] == DEPTH);
        assign empty_s[g] = (level_s[g] == '0);
    end

    // Bus decode, sticky overflow (set beats clear) and read mux.
    always_comb begin
        wr_s      = bus.chipselect && bus.write;
        rd_s      = bus.chipselect && bus.read;
        push_s[0] = wr_s && (bus.address == 4'd1);
        push_s[1] = wr_s && (bus.address == 4'd2);
        push_s[2] = wr_s && (bus.address == 4'd3);
        clr_s     = (wr_s && (bus.address == 4'd0)) ? bus.writedata[2:0] : 3'b000;
        ovf_d     = (ovf_q & ~clr_s) | (push_s & full_s);
        readdata_d = readdata_q;
        if (rd_s) begin
            case (bus.address)
                4'd0:    readdata_d = {{(DATA_W-9){1'b0}}, full_s, empty_s, ovf_q};
                4'd10:   readdata_d = DATA_W'(level_s[0]);
                4'd11:   readdata_d = DATA_W'(level_s[1]);
                4'd12:   readdata_d = DATA_W'(level_s[2]);
                4'd13:   readdata_d = DATA_W'(DEPTH - level_s[0]);
                4'd14:   readdata_d = DATA_W'(DEPTH - level_s[1]);
                4'd15:   readdata_d = DATA_W'(DEPTH - level_s[2]);
                default: readdata_d = DATA_W'(255);
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Overflow flags and bus read data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q      <= 3'b000;
            readdata_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata  = readdata_q;
    assign bus.input1    = data_s[0];
    assign bus.input2    = data_s[1];
    assign bus.input3    = data_s[2];
    assign bus.in_valid1 = valid_s[0];
    assign bus.in_valid2 = valid_s[1];
    assign bus.in_valid3 = valid_s[2];
endmodule

// File: tb/tb_ingress_buffer.sv
// Randomised and directed bench for ingress_buffer against a queue-based model.
module tb_ingress_buffer;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ingress_buffer_if #(.DATA_W(DW)) bus ();
    ingress_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int passes = 0;

    // Model: each accepted word with the edge number it was pushed at.
    logic [31:0] mq_d [3][$];
    int          mq_t [3][$];
    logic [2:0]  m_ovf = 3'b000;
    logic [31:0] m_rd = 32'h0;
    int          cyc = 0;
    int          popped [3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // A word is at the head of the stream two edges after its push at the earliest.
    function automatic logic m_valid(input int ch);
        return (mq_d[ch].size() > 0) && (mq_t[ch][0] + 2 <= cyc);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [2:0] f, e;
        for (int c = 0; c < 3; c++) begin
            f[c] = (mq_d[c].size() == DEPTH);
            e[c] = (mq_d[c].size() == 0);
        end
        case (a)
            4'd0:              return {23'd0, f, e, m_ovf};
            4'd10, 4'd11, 4'd12: return 32'(mq_d[int'(a) - 10].size());
            4'd13, 4'd14, 4'd15: return 32'(DEPTH - mq_d[int'(a) - 13].size());
            default:           return 32'd255;
        endcase
    endfunction

    function automatic logic tb_ready(input int ch);
        case (ch)
            0: return bus.in_ready1;
            1: return bus.in_ready2;
            default: return bus.in_ready3;
        endcase
    endfunction

    function automatic logic dut_valid(input int ch);
        case (ch)
            0: return bus.in_valid1;
            1: return bus.in_valid2;
            default: return bus.in_valid3;
        endcase
    endfunction

    function automatic logic [31:0] dut_data(input int ch);
        case (ch)
            0: return bus.input1;
            1: return bus.input2;
            default: return bus.input3;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] req, full, pop, clr;
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                mq_d[c].delete();
                mq_t[c].delete();
            end
            m_ovf = 3'b000;
            m_rd  = 32'h0;
        end else begin
            if (bus.chipselect && bus.read) m_rd = m_read(bus.address);
            for (int c = 0; c < 3; c++) begin
                req[c]  = bus.chipselect && bus.write && (int'(bus.address) == c + 1);
                full[c] = (mq_d[c].size() == DEPTH);
                pop[c]  = m_valid(c) && tb_ready(c);
            end
            clr = (bus.chipselect && bus.write && bus.address == 4'd0) ? bus.writedata[2:0] : 3'b000;
            m_ovf = (m_ovf & ~clr) | (req & full);
            for (int c = 0; c < 3; c++) begin
                if (pop[c]) begin
                    void'(mq_d[c].pop_front());
                    void'(mq_t[c].pop_front());
                    popped[c]++;
                end
                if (req[c] && !full[c]) begin
                    mq_d[c].push_back(bus.writedata);
                    mq_t[c].push_back(cyc + 1);
                end
            end
        end
        cyc++;
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every output against the model mid-cycle.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int c = 0; c < 3; c++) begin
                    check($sformatf("in_valid%0d", c + 1), 32'(dut_valid(c)), 32'(m_valid(c)));
                    if (m_valid(c)) check($sformatf("input%0d", c + 1), dut_data(c), mq_d[c][0]);
                end
                check("readdata", bus.readdata, m_rd);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        next();
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        next();
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    initial begin : stim
        int pushed;
        int base;
        logic done;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = 4'd0; bus.writedata = 32'h0;
        bus.in_ready1 = 1'b0; bus.in_ready2 = 1'b0; bus.in_ready3 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_valid", 32'({bus.in_valid3, bus.in_valid2, bus.in_valid1}), 32'h0);
        rd(4'd0);  check("rst_status", bus.readdata, 32'h38);
        rd(4'd10); check("rst_level1", bus.readdata, 32'd0);
        rd(4'd13); check("rst_free1", bus.readdata, 32'd16);
        rd(4'd5);  check("rd_unmapped", bus.readdata, 32'd255);

        // Latency, hold and back-to-back pops on channel 1
        wr(4'd1, 32'hA0); wr(4'd1, 32'hA1); wr(4'd1, 32'hA2);
        check("lat_valid1", 32'(bus.in_valid1), 32'd1);
        check("lat_input1", bus.input1, 32'hA0);
        repeat (3) next();
        check("hold_input1", bus.input1, 32'hA0);
        bus.in_ready1 = 1'b1;
        repeat (3) next();
        check("drain_valid1", 32'(bus.in_valid1), 32'd0);
        bus.in_ready1 = 1'b0;

        // Overflow on channel 2 and write-1-to-clear
        for (int i = 0; i < 17; i++) wr(4'd2, 32'h200 + 32'(i));
        repeat (2) next();
        rd(4'd11); check("full_level2", bus.readdata, 32'd16);
        rd(4'd0);
        check("full2_bit", 32'(bus.readdata[7]), 32'd1);
        check("ovf2_bit", 32'(bus.readdata[1]), 32'd1);
        wr(4'd0, 32'h2);
        rd(4'd0);  check("ovf2_clr", 32'(bus.readdata[1]), 32'd0);
        bus.in_ready2 = 1'b1;
        repeat (20) next();
        check("drain_valid2", 32'(bus.in_valid2), 32'd0);
        bus.in_ready2 = 1'b0;

        // Full channel 3: push and pop in the same cycle drops the push
        for (int i = 0; i < 16; i++) wr(4'd3, 32'h300 + 32'(i));
        repeat (3) next();
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd3; bus.writedata = 32'h3FF;
        bus.in_ready3 = 1'b1;
        next();
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.in_ready3 = 1'b0;
        rd(4'd12); check("pp_level3", bus.readdata, 32'd15);
        rd(4'd0);  check("pp_ovf3", 32'(bus.readdata[2]), 32'd1);
        wr(4'd0, 32'h7);
        bus.in_ready3 = 1'b1;
        repeat (20) next();
        bus.in_ready3 = 1'b0;

        // 40 words through channel 1 with random back-pressure, wrapping twice
        pushed = 0;
        base = popped[0];
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            bus.in_ready1 = 1'($urandom_range(0, 1));
            if (pushed < 40 && mq_d[0].size() < 15 && $urandom_range(0, 1) == 1) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd1;
                bus.writedata = 32'hC000 + 32'(pushed);
                pushed++;
            end else begin
                bus.chipselect = 1'b0; bus.write = 1'b0;
            end
            next();
            done = (pushed == 40) && (mq_d[0].size() == 0);
        end
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.in_ready1 = 1'b0;
        check("rand1_done", 32'(done), 32'd1);
        check("rand1_popped", 32'(popped[0] - base), 32'd40);
        rd(4'd10); check("rand1_level", bus.readdata, 32'd0);

        // Mixed random traffic on all channels and the register map
        for (int c = 0; c < 400; c++) begin
            bus.in_ready1 = 1'($urandom_range(0, 1));
            bus.in_ready2 = 1'($urandom_range(0, 3) == 0);
            bus.in_ready3 = 1'($urandom_range(0, 1));
            bus.chipselect = 1'($urandom_range(0, 3) != 0);
            bus.write = 1'($urandom_range(0, 1));
            bus.read = 1'($urandom_range(0, 1));
            bus.address = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
            bus.writedata = $urandom;
            next();
        end
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.in_ready1 = 1'b1; bus.in_ready2 = 1'b1; bus.in_ready3 = 1'b1;
        repeat (40) next();
        bus.in_ready1 = 1'b0; bus.in_ready2 = 1'b0; bus.in_ready3 = 1'b0;

        // Reset mid-operation
        for (int i = 0; i < 5; i++) wr(4'd1, 32'hD0 + 32'(i));
        repeat (3) next();
        check("pre_rst_valid1", 32'(bus.in_valid1), 32'd1);
        #2 reset = 1'b1;
        #1 check("rst_drop_valid1", 32'(bus.in_valid1), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd(4'd10); check("post_rst_level1", bus.readdata, 32'd0);
        rd(4'd0);  check("post_rst_status", bus.readdata, 32'h38);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
